// File: rtl/usb3_pkg.sv
// Shared constants, FSM encoding and helpers for the USB 3.0 header packet
// receive checker.
package usb3_pkg;

    localparam logic [7:0]  K_SHP        = 8'hFB;
    localparam logic [7:0]  K_EPF        = 8'hF7;
    localparam logic [31:0] HPSTART_WORD = {K_EPF, K_SHP, K_SHP, K_SHP};

    localparam logic [15:0] CRC16_POLY = 16'h100B;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;
    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_SEED  = 5'h1F;

    // Link control word layout (LCW = dword3[31:16])
    localparam int LCW_SEQ_LSB  = 0;
    localparam int LCW_HUB_LSB  = 6;
    localparam int LCW_DLY_BIT  = 9;
    localparam int LCW_DEF_BIT  = 10;
    localparam int LCW_CRC5_LSB = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DW0,
        ST_DW1,
        ST_DW2,
        ST_DW3
    } hp_state_e;

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb3_crc16_step.sv
// Combinational CRC-16 LFSR advance over one 32-bit dword, bit 0 first.
// The caller owns the LFSR register.
module usb3_crc16_step
    import usb3_pkg::*;
(
    input  logic [15:0] lfsr_in,
    input  logic [31:0] data_in,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_v;
    logic        fb;

    // NOTE: blocking assignments here are deliberate: the loop unrolls into a
    // chain of XOR stages, each consuming the previous stage's value.
    always_comb begin
        lfsr_v = lfsr_in;
        fb     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fb     = lfsr_v[15] ^ data_in[i];
            lfsr_v = {lfsr_v[14:0], 1'b0};
            if (fb) begin
                lfsr_v = lfsr_v ^ CRC16_POLY;
            end
        end
        lfsr_out = lfsr_v;
    end

endmodule

// File: rtl/usb3_hp_rx_check.sv
// Receive-side header packet checker: frames HPSTART + 4 dwords, verifies the
// header CRC-16 and LCW CRC-5, and reports status to the link-layer FSM.
module usb3_hp_rx_check
    import usb3_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          in_data,
    input  logic [3:0]           in_datak,
    input  logic                 in_active,
    output logic [95:0]          hdr_dw,
    output logic [2:0]           hdr_seq,
    output logic [2:0]           hdr_hub_depth,
    output logic                 hdr_delayed,
    output logic                 hdr_deferred,
    output logic                 hdr_valid,
    output logic                 hdr_crc16_err,
    output logic                 hdr_crc5_err,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] crc_err_cnt,
    output logic [ERR_CNT_W-1:0] frame_err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    function automatic logic [4:0] crc5_calc(input logic [10:0] d);
        logic [4:0] c;
        logic       fb;
        c = CRC5_SEED;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0};
            if (fb) begin
                c = c ^ CRC5_POLY;
            end
        end
        return ~c;
    endfunction

    hp_state_e             state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d, lfsr_step;
    logic [2:0][31:0]      cap_q, cap_d;
    logic [95:0]           hdr_dw_q, hdr_dw_d;
    logic [2:0]            hdr_seq_q, hdr_seq_d;
    logic [2:0]            hdr_hub_q, hdr_hub_d;
    logic                  hdr_dly_q, hdr_dly_d;
    logic                  hdr_def_q, hdr_def_d;
    logic                  hdr_valid_q, hdr_valid_d;
    logic                  crc16_err_q, crc16_err_d;
    logic                  crc5_err_q, crc5_err_d;
    logic                  frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0]  crc_cnt_q, crc_cnt_d;
    logic [ERR_CNT_W-1:0]  frm_cnt_q, frm_cnt_d;

    logic        is_hpstart;
    logic        abort;
    logic [15:0] lcw;

    usb3_crc16_step u_crc16_step (
        .lfsr_in  (lfsr_q),
        .data_in  (in_data),
        .lfsr_out (lfsr_step)
    );

    assign is_hpstart = (in_datak == 4'hF) && (in_data == HPSTART_WORD);
    assign lcw        = in_data[31:16];

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cap_d       = cap_q;
        hdr_dw_d    = hdr_dw_q;
        hdr_seq_d   = hdr_seq_q;
        hdr_hub_d   = hdr_hub_q;
        hdr_dly_d   = hdr_dly_q;
        hdr_def_d   = hdr_def_q;
        hdr_valid_d = 1'b0;
        crc16_err_d = 1'b0;
        crc5_err_d  = 1'b0;
        frame_err_d = 1'b0;
        crc_cnt_d   = crc_cnt_q;
        frm_cnt_d   = frm_cnt_q;
        abort       = 1'b0;

        if (in_active) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_hpstart) begin
                        state_d = ST_DW0;
                        lfsr_d  = CRC16_SEED;
                    end
                end
                ST_DW0, ST_DW1, ST_DW2: begin
                    if (|in_datak) begin
                        abort = 1'b1;
                    end else begin
                        lfsr_d = lfsr_step;
                        if (state_q == ST_DW0) begin
                            cap_d[0] = in_data;
                            state_d  = ST_DW1;
                        end else if (state_q == ST_DW1) begin
                            cap_d[1] = in_data;
                            state_d  = ST_DW2;
                        end else begin
                            cap_d[2] = in_data;
                            state_d  = ST_DW3;
                        end
                    end
                end
                ST_DW3: begin
                    if (|in_datak) begin
                        abort = 1'b1;
                    end else begin
                        hdr_valid_d = 1'b1;
                        crc16_err_d = (~bitrev16(lfsr_q)) != in_data[15:0];
                        crc5_err_d  = crc5_calc(lcw[10:0]) != lcw[15:LCW_CRC5_LSB];
                        hdr_dw_d    = cap_q;
                        hdr_seq_d   = lcw[LCW_SEQ_LSB +: 3];
                        hdr_hub_d   = lcw[LCW_HUB_LSB +: 3];
                        hdr_dly_d   = lcw[LCW_DLY_BIT];
                        hdr_def_d   = lcw[LCW_DEF_BIT];
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A fresh HPSTART inside a packet restarts framing rather than idling.
        if (abort) begin
            frame_err_d = 1'b1;
            if (is_hpstart) begin
                state_d = ST_DW0;
                lfsr_d  = CRC16_SEED;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (hdr_valid_d && (crc16_err_d || crc5_err_d) && (crc_cnt_q != CNT_MAX)) begin
            crc_cnt_d = crc_cnt_q + ERR_CNT_W'(1);
        end
        if (frame_err_d && (frm_cnt_q != CNT_MAX)) begin
            frm_cnt_d = frm_cnt_q + ERR_CNT_W'(1);
        end
    end

    // NOTE: the capture and header registers are reset along with control so
    // outputs read 0 after reset, not stale data from an earlier packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= CRC16_SEED;
            cap_q       <= '0;
            hdr_dw_q    <= '0;
            hdr_seq_q   <= '0;
            hdr_hub_q   <= '0;
            hdr_dly_q   <= 1'b0;
            hdr_def_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            crc16_err_q <= 1'b0;
            crc5_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            crc_cnt_q   <= '0;
            frm_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cap_q       <= cap_d;
            hdr_dw_q    <= hdr_dw_d;
            hdr_seq_q   <= hdr_seq_d;
            hdr_hub_q   <= hdr_hub_d;
            hdr_dly_q   <= hdr_dly_d;
            hdr_def_q   <= hdr_def_d;
            hdr_valid_q <= hdr_valid_d;
            crc16_err_q <= crc16_err_d;
            crc5_err_q  <= crc5_err_d;
            frame_err_q <= frame_err_d;
            crc_cnt_q   <= crc_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
        end
    end

    assign hdr_dw        = hdr_dw_q;
    assign hdr_seq       = hdr_seq_q;
    assign hdr_hub_depth = hdr_hub_q;
    assign hdr_delayed   = hdr_dly_q;
    assign hdr_deferred  = hdr_def_q;
    assign hdr_valid     = hdr_valid_q;
    assign hdr_crc16_err = crc16_err_q;
    assign hdr_crc5_err  = crc5_err_q;
    assign frame_err     = frame_err_q;
    assign crc_err_cnt   = crc_cnt_q;
    assign frame_err_cnt = frm_cnt_q;

endmodule

// File: tb/tb_usb3_hp_rx_check.sv
// Self-checking bench for usb3_hp_rx_check: a bit-serial stream model computes
// golden CRCs and expected strobe timing; a monitor logs every strobe.
module tb_usb3_hp_rx_check;

    localparam logic [31:0] HPS = 32'hF7FBFBFB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        in_active;
    logic [95:0] hdr_dw;
    logic [2:0]  hdr_seq, hdr_hub_depth;
    logic        hdr_delayed, hdr_deferred, hdr_valid;
    logic        hdr_crc16_err, hdr_crc5_err, frame_err;
    logic [7:0]  crc_err_cnt, frame_err_cnt;

    usb3_hp_rx_check #(.ERR_CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_datak      (in_datak),
        .in_active     (in_active),
        .hdr_dw        (hdr_dw),
        .hdr_seq       (hdr_seq),
        .hdr_hub_depth (hdr_hub_depth),
        .hdr_delayed   (hdr_delayed),
        .hdr_deferred  (hdr_deferred),
        .hdr_valid     (hdr_valid),
        .hdr_crc16_err (hdr_crc16_err),
        .hdr_crc5_err  (hdr_crc5_err),
        .frame_err     (frame_err),
        .crc_err_cnt   (crc_err_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ts;
        logic [95:0] dw;
        logic [2:0]  seq;
        logic [2:0]  hub;
        logic        dly;
        logic        dfr;
        logic        e16;
        logic        e5;
    } ev_t;

    int   cyc = 0;
    int   last_acc;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_crc_cnt = 0;
    int   exp_frm_cnt = 0;
    ev_t  ev_q[$];
    int   fe_q[$];
    ev_t  mon_ev;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (hdr_valid === 1'b1) begin
            mon_ev.ts  = cyc;
            mon_ev.dw  = hdr_dw;
            mon_ev.seq = hdr_seq;
            mon_ev.hub = hdr_hub_depth;
            mon_ev.dly = hdr_delayed;
            mon_ev.dfr = hdr_deferred;
            mon_ev.e16 = hdr_crc16_err;
            mon_ev.e5  = hdr_crc5_err;
            ev_q.push_back(mon_ev);
        end
        if (frame_err === 1'b1) fe_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Header bits in wire order are simply hdr[0], hdr[1], ... hdr[95].
    function automatic logic [15:0] ref_crc16(input logic [95:0] hdr);
        logic [15:0] r;
        logic [15:0] res;
        r = 16'hFFFF;
        for (int i = 0; i < 96; i++)
            r = {r[14:0], 1'b0} ^ (((r[15] ^ hdr[i]) != 1'b0) ? 16'h100B : 16'h0000);
        for (int j = 0; j < 16; j++) res[j] = ~r[15-j];
        return res;
    endfunction

    function automatic logic [4:0] ref_crc5(input logic [10:0] l);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 11; i++)
            r = {r[3:0], 1'b0} ^ (((r[4] ^ l[i]) != 1'b0) ? 5'h05 : 5'h00);
        return ~r;
    endfunction

    function automatic logic [31:0] make_dw3(input logic [95:0] hdr, input logic [10:0] l);
        return {ref_crc5(l), l, ref_crc16(hdr)};
    endfunction

    function automatic ev_t exp_ev(input int ts, input logic [95:0] hdr, input logic [31:0] dw3);
        ev_t e;
        e.ts  = ts;
        e.dw  = hdr;
        e.seq = dw3[18:16];
        e.hub = dw3[24:22];
        e.dly = dw3[25];
        e.dfr = dw3[26];
        e.e16 = ref_crc16(hdr) != dw3[15:0];
        e.e5  = ref_crc5(dw3[26:16]) != dw3[31:27];
        return e;
    endfunction

    function automatic logic [95:0] rand_hdr();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic a);
        @(negedge clk);
        in_data   = d;
        in_datak  = k;
        in_active = a;
        last_acc  = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat($urandom(), 4'h0, 1'b1);
    endtask

    task automatic send_body(input logic [95:0] hdr, input logic [31:0] dw3, output int acc);
        beat(hdr[31:0], 4'h0, 1'b1);
        beat(hdr[63:32], 4'h0, 1'b1);
        beat(hdr[95:64], 4'h0, 1'b1);
        beat(dw3, 4'h0, 1'b1);
        acc = last_acc;
    endtask

    task automatic send_pkt(input logic [95:0] hdr, input logic [31:0] dw3, output int acc);
        beat(HPS, 4'hF, 1'b1);
        send_body(hdr, dw3, acc);
    endtask

    // Model of the saturating counters, stepped from expected packet outcomes.
    task automatic model_count(input ev_t e);
        if ((e.e16 || e.e5) && exp_crc_cnt < 255) exp_crc_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_data = '0; in_datak = '0; in_active = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({hdr_dw, hdr_seq, hdr_hub_depth, hdr_delayed, hdr_deferred, hdr_valid,
             hdr_crc16_err, hdr_crc5_err, frame_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got hdr_dw=%h valid=%b fe=%b, want all 0", hdr_dw, hdr_valid, frame_err);
        end
        n_cmp++;
        if ({crc_err_cnt, frame_err_cnt} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_counters: got %h/%h, want 0/0", crc_err_cnt, frame_err_cnt);
        end
        rst = 1'b0;
        idle(2);
        ev_q.delete();
        fe_q.delete();
    endtask

    task automatic test_good();
        logic [95:0] hdr;
        logic [31:0] dw3;
        ev_t e, g;
        int acc;
        hdr = {32'h0, 32'h0, 32'h00000020};
        dw3 = make_dw3(hdr, 11'h405);
        send_pkt(hdr, dw3, acc);
        idle(3);
        e = exp_ev(acc, hdr, dw3);
        n_cmp++;
        if (ev_q.size() != 1) begin
            n_bad++;
            $display("FAIL good_strobe_count: got %0d hdr_valid pulses, want 1", ev_q.size());
        end
        g = (ev_q.size() > 0) ? ev_q[0] : '0;
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL good_header: got %h want %h", g, e);
        end
        n_cmp++;
        if (hdr_seq !== 3'd5 || hdr_deferred !== 1'b1) begin
            n_bad++;
            $display("FAIL good_lcw_fields: got seq=%0d deferred=%b, want 5/1", hdr_seq, hdr_deferred);
        end
        n_cmp++;
        if (crc_err_cnt !== 8'd0 || frame_err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL good_counters: got %0d/%0d want 0/0", crc_err_cnt, frame_err_cnt);
        end
        ev_q.delete();
        for (int i = 0; i < 6; i++) begin
            hdr = rand_hdr();
            dw3 = make_dw3(hdr, 11'($urandom()));
            send_pkt(hdr, dw3, acc);
            idle(3);
            e = exp_ev(acc, hdr, dw3);
            g = (ev_q.size() == 1) ? ev_q[0] : '0;
            n_cmp++;
            if (ev_q.size() != 1 || g !== e) begin
                n_bad++;
                $display("FAIL rand_good_%0d: got %0d strobes %h want %h", i, ev_q.size(), g, e);
            end
            ev_q.delete();
        end
    endtask

    task automatic test_crc_err();
        logic [95:0] hdr;
        logic [31:0] dw3;
        ev_t e, g;
        int acc;
        hdr = {32'h0, 32'h0, 32'h00000020};
        for (int pass = 0; pass < 2; pass++) begin
            dw3 = make_dw3(hdr, 11'h405) ^ ((pass == 0) ? 32'h0000_0001 : 32'h0800_0000);
            send_pkt(hdr, dw3, acc);
            idle(3);
            e = exp_ev(acc, hdr, dw3);
            model_count(e);
            g = (ev_q.size() == 1) ? ev_q[0] : '0;
            n_cmp++;
            if (ev_q.size() != 1 || g !== e) begin
                n_bad++;
                $display("FAIL crc_err_flags_%0d: got %0d strobes %h want %h", pass, ev_q.size(), g, e);
            end
            n_cmp++;
            if (crc_err_cnt !== 8'(exp_crc_cnt)) begin
                n_bad++;
                $display("FAIL crc_err_cnt_%0d: got %0d want %0d", pass, crc_err_cnt, exp_crc_cnt);
            end
            ev_q.delete();
        end
    endtask

    task automatic test_abort();
        logic [95:0] hdr;
        logic [31:0] dw3;
        ev_t e, g;
        int acc_a, acc_b, acc_c;
        hdr = rand_hdr();
        dw3 = make_dw3(hdr, 11'($urandom()));
        beat(HPS, 4'hF, 1'b1);
        beat(hdr[31:0], 4'h0, 1'b1);
        beat($urandom(), 4'h1, 1'b1);
        acc_a = last_acc;
        exp_frm_cnt++;
        idle(3);
        n_cmp++;
        if (fe_q.size() != 1 || ev_q.size() != 0 || fe_q[0] != acc_a) begin
            n_bad++;
            $display("FAIL abort_k: got %0d frame_err %0d hdr_valid, want 1 frame_err at %0d and 0 hdr_valid",
                     fe_q.size(), ev_q.size(), acc_a);
        end
        n_cmp++;
        if (frame_err_cnt !== 8'(exp_frm_cnt)) begin
            n_bad++;
            $display("FAIL abort_k_cnt: got %0d want %0d", frame_err_cnt, exp_frm_cnt);
        end
        fe_q.delete();
        beat(HPS, 4'hF, 1'b1);
        beat($urandom(), 4'h0, 1'b1);
        beat($urandom(), 4'h0, 1'b1);
        beat(HPS, 4'hF, 1'b1);
        acc_b = last_acc;
        exp_frm_cnt++;
        send_body(hdr, dw3, acc_c);
        idle(3);
        e = exp_ev(acc_c, hdr, dw3);
        g = (ev_q.size() == 1) ? ev_q[0] : '0;
        n_cmp++;
        if (fe_q.size() != 1 || fe_q[0] != acc_b) begin
            n_bad++;
            $display("FAIL abort_restart_fe: got %0d frame_err pulses, want 1 at %0d", fe_q.size(), acc_b);
        end
        n_cmp++;
        if (ev_q.size() != 1 || g !== e) begin
            n_bad++;
            $display("FAIL abort_restart_pkt: got %0d strobes %h want %h", ev_q.size(), g, e);
        end
        n_cmp++;
        if (frame_err_cnt !== 8'(exp_frm_cnt)) begin
            n_bad++;
            $display("FAIL abort_restart_cnt: got %0d want %0d", frame_err_cnt, exp_frm_cnt);
        end
        ev_q.delete();
        fe_q.delete();
    endtask

    task automatic test_stall();
        logic [95:0] hdr;
        logic [31:0] dw3;
        ev_t e, g;
        hdr = rand_hdr();
        dw3 = make_dw3(hdr, 11'($urandom()));
        beat(HPS, 4'hF, 1'b1);
        beat(hdr[31:0], 4'h0, 1'b1);
        beat(hdr[63:32], 4'h0, 1'b1);
        beat(HPS, 4'hF, 1'b0);
        beat($urandom(), 4'h1, 1'b0);
        beat($urandom(), 4'h0, 1'b0);
        beat(hdr[95:64], 4'h0, 1'b1);
        beat(dw3, 4'h0, 1'b1);
        e = exp_ev(last_acc, hdr, dw3);
        idle(3);
        g = (ev_q.size() == 1) ? ev_q[0] : '0;
        n_cmp++;
        if (ev_q.size() != 1 || g !== e) begin
            n_bad++;
            $display("FAIL stall_pkt: got %0d strobes %h want %h", ev_q.size(), g, e);
        end
        n_cmp++;
        if (fe_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_no_abort: got %0d frame_err pulses, want 0", fe_q.size());
        end
        ev_q.delete();
        fe_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [95:0] ha, hb;
        logic [31:0] da, db;
        ev_t ea, eb, ga, gb;
        int acc_a, acc_b;
        ha = rand_hdr();
        hb = rand_hdr();
        da = make_dw3(ha, 11'($urandom()));
        db = make_dw3(hb, 11'($urandom()));
        send_pkt(ha, da, acc_a);
        send_pkt(hb, db, acc_b);
        idle(3);
        ea = exp_ev(acc_a, ha, da);
        eb = exp_ev(acc_b, hb, db);
        ga = (ev_q.size() == 2) ? ev_q[0] : '0;
        gb = (ev_q.size() == 2) ? ev_q[1] : '0;
        n_cmp++;
        if (ev_q.size() != 2 || ga !== ea || gb !== eb || (gb.ts - ga.ts) != 5) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d strobes %h / %h want %h / %h",
                     ev_q.size(), ga, gb, ea, eb);
        end
        ev_q.delete();
        fe_q.delete();
        // Reset lands while the checker waits for dword 2.
        beat(HPS, 4'hF, 1'b1);
        beat(ha[31:0], 4'h0, 1'b1);
        beat(ha[63:32], 4'h0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_data = ha[95:64]; in_datak = 4'h0; in_active = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_data = da;
        idle(4);
        exp_crc_cnt = 0;
        exp_frm_cnt = 0;
        n_cmp++;
        if (ev_q.size() != 0 || fe_q.size() != 0) begin
            n_bad++;
            $display("FAIL rst_mid_strobe: got %0d hdr_valid %0d frame_err, want 0/0", ev_q.size(), fe_q.size());
        end
        n_cmp++;
        if ({hdr_dw, hdr_seq, hdr_hub_depth, hdr_delayed, hdr_deferred,
             crc_err_cnt, frame_err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got hdr_dw=%h cnt=%0d/%0d want all 0", hdr_dw, crc_err_cnt, frame_err_cnt);
        end
        ev_q.delete();
        fe_q.delete();
    endtask

    task automatic test_saturate();
        logic [95:0] hdr;
        logic [31:0] dw3;
        int acc, n_e16;
        for (int i = 0; i < 260; i++) begin
            hdr = rand_hdr();
            dw3 = make_dw3(hdr, 11'($urandom())) ^ 32'h0000_0001;
            model_count(exp_ev(0, hdr, dw3));
            send_pkt(hdr, dw3, acc);
            if (i == 253) begin
                idle(2);
                n_cmp++;
                if (crc_err_cnt !== 8'(exp_crc_cnt)) begin
                    n_bad++;
                    $display("FAIL sat_pre: got %0d want %0d", crc_err_cnt, exp_crc_cnt);
                end
            end
        end
        idle(3);
        n_cmp++;
        if (crc_err_cnt !== 8'hFF || exp_crc_cnt != 255) begin
            n_bad++;
            $display("FAIL sat_final: got %0d want 255 (model %0d)", crc_err_cnt, exp_crc_cnt);
        end
        n_e16 = 0;
        foreach (ev_q[i]) if (ev_q[i].e16 === 1'b1) n_e16++;
        n_cmp++;
        if (n_e16 != 260 || ev_q.size() != 260) begin
            n_bad++;
            $display("FAIL sat_strobes: got %0d strobes, %0d with crc16 error, want 260/260", ev_q.size(), n_e16);
        end
        n_cmp++;
        if (frame_err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL sat_frame_cnt: got %0d want 0", frame_err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_err();
        test_abort();
        test_stall();
        test_back_to_back();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
